// File: rtl/gpu_led_pkg.sv
// Shared types and defaults for the LED status driver: display modes,
// handshake FSM states and the mode-decoding helper.
package gpu_led_pkg;

  localparam int DEF_N_LEDS   = 16;
  localparam int DEF_PWM_BITS = 8;
  localparam int DEF_STEP_DIV = 25_000_000;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_CHASE  = 2'd2
  } led_mode_t;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } led_state_t;

  // The reserved encoding 3 collapses onto STATIC so it never animates.
  function automatic led_mode_t to_mode(input logic [1:0] m);
    led_mode_t r;
    case (m)
      2'd1:    r = MODE_BLINK;
      2'd2:    r = MODE_CHASE;
      default: r = MODE_STATIC;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/led_status_driver_if.sv
// Display-command channel into the LED status driver.
//
// Handshake: a command transfers on a rising clk edge where both in_valid
// and in_ready are 1. The master holds in_pattern/in_mode/in_bright stable
// while in_valid is 1; in_ready may drop at any time and does not depend
// on in_valid.
interface led_status_driver_if #(
  parameter int N_LEDS   = 16,
  parameter int PWM_BITS = 8
);
  logic                in_valid;
  logic                in_ready;
  logic [N_LEDS-1:0]   in_pattern;
  logic [1:0]          in_mode;
  logic [PWM_BITS-1:0] in_bright;

  modport master (output in_valid, output in_pattern, output in_mode,
                  output in_bright, input in_ready);
  modport slave  (input in_valid, input in_pattern, input in_mode,
                  input in_bright, output in_ready);
endinterface

// File: rtl/led_pwm_gen.sv
// Free-running PWM frame counter: flags the last cycle of each frame and
// reports whether the current slot is lit for a given brightness.
module led_pwm_gen #(
  parameter int PWM_BITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [PWM_BITS-1:0] eff_bright_i,
  output logic                frame_end_o,
  output logic                pwm_on_o
);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;

  assign pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);

  always_ff @(posedge clk) begin
    if (rst) pwm_cnt_q <= '0;
    else     pwm_cnt_q <= pwm_cnt_d;
  end

  assign frame_end_o = (pwm_cnt_q == {PWM_BITS{1'b1}});
  // Strict compare: brightness max is lit for all but the last slot.
  assign pwm_on_o    = (pwm_cnt_q < eff_bright_i);

endmodule

// File: rtl/led_status_driver.sv
// LED output stage: accepts display commands, commits them at PWM frame
// boundaries, animates (static/blink/chase) and PWM-dims the led bus.
// Define LED_GAMMA_EN to apply a square-law brightness curve at commit.
module led_status_driver
  import gpu_led_pkg::*;
#(
  parameter int N_LEDS   = DEF_N_LEDS,
  parameter int PWM_BITS = DEF_PWM_BITS,
  parameter int STEP_DIV = DEF_STEP_DIV
) (
  input  logic                 clk,
  input  logic                 rst,
  led_status_driver_if.slave   cmd,
  output logic [N_LEDS-1:0]    led,
  output led_state_t           dbg_state_o
);

  localparam int SW = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_DIV - 1);

  led_state_t          state_q, state_d;
  logic                in_ready, accept, commit;
  logic                frame_end, pwm_on, step;

  logic [N_LEDS-1:0]   sh_pattern_q, sh_pattern_d;
  led_mode_t           sh_mode_q, sh_mode_d;
  logic [PWM_BITS-1:0] sh_bright_q, sh_bright_d;
  logic [PWM_BITS-1:0] eff_shadow;

  logic [N_LEDS-1:0]   act_pattern_q, act_pattern_d;
  led_mode_t           act_mode_q, act_mode_d;
  logic [PWM_BITS-1:0] act_bright_q, act_bright_d;

  logic [SW-1:0]       step_cnt_q, step_cnt_d;
  logic                phase_q, phase_d;
  logic [N_LEDS-1:0]   disp, led_q, led_d;

  led_pwm_gen #(.PWM_BITS(PWM_BITS)) u_pwm (
    .clk          (clk),
    .rst          (rst),
    .eff_bright_i (act_bright_q),
    .frame_end_o  (frame_end),
    .pwm_on_o     (pwm_on)
  );

`ifdef LED_GAMMA_EN
  logic [2*PWM_BITS-1:0] bright_sq;
  assign bright_sq  = {{PWM_BITS{1'b0}}, sh_bright_q} * {{PWM_BITS{1'b0}}, sh_bright_q};
  assign eff_shadow = bright_sq[2*PWM_BITS-1:PWM_BITS];
`else
  assign eff_shadow = sh_bright_q;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (accept)    state_d = ST_PENDING;
      ST_PENDING: if (frame_end) state_d = ST_IDLE;
      default:                   state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready = (state_q == ST_IDLE) && !rst;
    accept   = cmd.in_valid && in_ready;
    commit   = (state_q == ST_PENDING) && frame_end;
  end

  assign cmd.in_ready = in_ready;
  assign dbg_state_o  = state_q;
  assign step         = (step_cnt_q == STEP_LAST);

  // A commit on a step edge wins: the new command starts un-animated.
  always_comb begin
    sh_pattern_d  = sh_pattern_q;
    sh_mode_d     = sh_mode_q;
    sh_bright_d   = sh_bright_q;
    act_pattern_d = act_pattern_q;
    act_mode_d    = act_mode_q;
    act_bright_d  = act_bright_q;
    step_cnt_d    = step_cnt_q + SW'(1);
    phase_d       = phase_q;
    if (accept) begin
      sh_pattern_d = cmd.in_pattern;
      sh_mode_d    = to_mode(cmd.in_mode);
      sh_bright_d  = cmd.in_bright;
    end
    if (commit) begin
      act_pattern_d = sh_pattern_q;
      act_mode_d    = sh_mode_q;
      act_bright_d  = eff_shadow;
      step_cnt_d    = '0;
      phase_d       = 1'b1;
    end else if (step) begin
      step_cnt_d = '0;
      case (act_mode_q)
        MODE_BLINK: phase_d       = ~phase_q;
        MODE_CHASE: act_pattern_d = {act_pattern_q[N_LEDS-2:0], act_pattern_q[N_LEDS-1]};
        default:    ;
      endcase
    end
  end

  assign disp  = (act_mode_q == MODE_BLINK && !phase_q) ? '0 : act_pattern_q;
  assign led_d = disp & {N_LEDS{pwm_on}};

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_pattern_q  <= '0;
      sh_mode_q     <= MODE_STATIC;
      sh_bright_q   <= '0;
      act_pattern_q <= '0;
      act_mode_q    <= MODE_STATIC;
      act_bright_q  <= '0;
      step_cnt_q    <= '0;
      phase_q       <= 1'b1;
      led_q         <= '0;
    end else begin
      sh_pattern_q  <= sh_pattern_d;
      sh_mode_q     <= sh_mode_d;
      sh_bright_q   <= sh_bright_d;
      act_pattern_q <= act_pattern_d;
      act_mode_q    <= act_mode_d;
      act_bright_q  <= act_bright_d;
      step_cnt_q    <= step_cnt_d;
      phase_q       <= phase_d;
      led_q         <= led_d;
    end
  end

  assign led = led_q;

endmodule

// File: doc/led_status_driver.md
Name: led_status_driver

Overview:
- Final output stage inside `top` that drives the 16-bit `led` bus seen at the top-level pins and by the top-level bench.
- Accepts display commands (pattern, mode, brightness) from upstream logic over a valid/ready handshake.
- Dims the LEDs by PWM and animates them (static / blink / chase).
- Commits new commands only at PWM frame boundaries, so the LEDs never glitch mid-frame.

Parameters:
- N_LEDS, 16, width of pattern and `led` bus.
- PWM_BITS, 8, brightness resolution; PWM frame = 2^PWM_BITS clk cycles.
- STEP_DIV, 25_000_000, clk cycles per animation step (4 Hz at 100 MHz); must be >= 2.

Ports:
- clk  in  1  system clock, 100 MHz.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  command valid.
- in_ready  out  1  block can accept a command.
- in_pattern  in  N_LEDS  LED bit pattern.
- in_mode  in  2  0 STATIC, 1 BLINK, 2 CHASE, 3 reserved (treated as STATIC).
- in_bright  in  PWM_BITS  brightness, 0 = off.
- led  out  N_LEDS  registered LED drive.

Behaviour:
- Reset (synchronous, active-high): while `rst` is high, all of the following are forced on the next edge:
  - `led`=0, pwm_cnt=0, step_cnt=0, phase=1.
  - Active pattern/mode/bright = 0 / STATIC / 0.
  - Shadow command cleared; FSM=IDLE.
  - `in_ready` is combinationally 0.
- Reset mid-operation: reset asserted in PENDING discards the shadow command.
- pwm_cnt: free-running PWM_BITS-bit counter, wraps max->0. frame_end = (pwm_cnt == 2^PWM_BITS-1).
- FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch pattern/mode/bright into the shadow registers and go to PENDING.
  - PENDING: in_ready=0; in_valid is ignored. On frame_end, go to IDLE; on that same edge, copy shadow to active, clear step_cnt and set phase=1.
  - Accept-to-commit latency: 1 to 2^PWM_BITS cycles.
  - Accept in the same cycle as frame_end: the command is latched only and commits at the next frame_end, not that one.
- Step tick: step_cnt counts 0..STEP_DIV-1 and pulses step on wrap.
  - A commit on the same edge as a step takes priority: step_cnt is cleared and no animation advance happens.
- Animation, applied to the active pattern on a step:
  - BLINK: phase toggles.
  - CHASE: active pattern rotates left by 1, bit N_LEDS-1 -> bit 0.
  - STATIC: no change.
- Display word: disp = (mode==BLINK && !phase) ? 0 : active_pattern.
- Output: `led` registered, one-cycle latency: led <= disp & {N_LEDS{pwm_cnt < eff_bright}}.
  - eff_bright = active bright (linear).
  - bright=0 -> LEDs always off.
  - bright=max -> on (2^PWM_BITS-1) of 2^PWM_BITS cycles; full-on is never reached (decided).
- Width rules:
  - Compare is unsigned, PWM_BITS wide.
  - CHASE with pattern 0 stays 0; with all-ones it stays all-ones.

Optional Feature:
- Macro: LED_GAMMA_EN.
- Defined: eff_bright = (bright*bright) >> PWM_BITS, computed from a 2*PWM_BITS-bit product and registered at commit. Values for PWM_BITS=8:
  - 255 -> 254
  - 128 -> 64
  - 16 -> 1
  - 15 -> 0
- Undefined: eff_bright = bright; no multiplier is instantiated.

Decomposition:
- Package `gpu_led_pkg`:
  - led_mode_t enum (MODE_STATIC=2'd0, MODE_BLINK=2'd1, MODE_CHASE=2'd2).
  - led_state_t enum (ST_IDLE, ST_PENDING).
  - Default-value localparams.
- Sub-module `led_pwm_gen`:
  - Holds pwm_cnt, the frame_end flag and the compare-vs-eff_bright logic.
  - Outputs frame_end and pwm_on.
  - The top-level block keeps the FSM, shadow/active registers and animation.

Test Plan (PWM_BITS=8, STEP_DIV=16 in bench):
- Reset: hold rst 3 cycles -> led=0, in_ready=0 during reset; in_ready=1 on the first cycle after release; led stays 0 for 512 cycles.
- Static dim: send pattern 16'hA5A5, STATIC, bright=64 -> in_ready drops next cycle; after commit, led=16'hA5A5 for exactly 64 of every 256 cycles, 0 for the rest.
- Frame-boundary commit: assert valid when pwm_cnt=10 with bright=255 -> no led change until cycle after pwm_cnt=255; a second valid during PENDING is not accepted (in_ready=0) and is not applied.
- Chase wrap: pattern 16'h8000, CHASE, bright=255 -> after 16 cycles the pattern becomes 16'h0001, then 16'h0002 16 cycles later.
- Blink: pattern 16'hFFFF, BLINK, bright=255 -> LEDs visible for 16 cycles, dark for 16 cycles, repeating; commit restarts with the visible phase.
- Gamma (LED_GAMMA_EN): bright=128 -> on 64 of 256 cycles; bright=15 -> led always 0. Without the macro: bright=15 -> on 15 of 256 cycles.
